// File: rtl/rpsc_pkg.sv
// Shared channel count, channel-vector type and debounce FSM states for the
// card-11 input conditioning stage.
package rpsc_pkg;

  localparam int RPSC_NUM_FF_CH = 7;

  typedef logic [RPSC_NUM_FF_CH-1:0] rpsc_ch_vec_t;

  typedef enum logic {
    DB_STABLE,
    DB_PENDING
  } rpsc_db_state_t;

endpackage

// File: rtl/rpsc_debounce_ch.sv
// One contact channel: 2-flop synchroniser, debounce FSM with run counter,
// saturating abort counter and sticky chatter flag.
module rpsc_debounce_ch
  import rpsc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CHATTER_MAX  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic clr_chatter,
  output logic clean_out,
  output logic change_stb,
  output logic chatter
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int AW = $clog2(CHATTER_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [AW-1:0] ABORT_MAX = AW'(CHATTER_MAX);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  rpsc_db_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  abort_q, abort_d;
  logic           clean_q, clean_d;
  logic           stb_q, stb_d;
  logic           chatter_q, chatter_d;
  logic           abort_evt;

  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    clean_d   = clean_q;
    stb_d     = 1'b0;
    abort_evt = 1'b0;

    case (state_q)
      DB_STABLE: begin
        if (sync2_q != clean_q) begin
          state_d = DB_PENDING;
          cnt_d   = CW'(1);
        end
      end
      DB_PENDING: begin
        if (sync2_q != clean_q) begin
          // The sample that would bring cnt to DEBOUNCE_CYC commits the change.
          if (cnt_q == CNT_LAST) begin
            clean_d = sync2_q;
            stb_d   = 1'b1;
            cnt_d   = '0;
            abort_d = '0;
            state_d = DB_STABLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          abort_evt = 1'b1;
          cnt_d     = '0;
          state_d   = DB_STABLE;
          if (abort_q != ABORT_MAX) abort_d = abort_q + AW'(1);
        end
      end
      default: state_d = DB_STABLE;
    endcase

    // Any abort at the saturated count re-arms the flag, overriding a clear.
    chatter_d = (abort_evt && (abort_d == ABORT_MAX)) || (chatter_q && !clr_chatter);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= DB_STABLE;
      cnt_q     <= '0;
      abort_q   <= '0;
      clean_q   <= 1'b0;
      stb_q     <= 1'b0;
      chatter_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      clean_q   <= clean_d;
      stb_q     <= stb_d;
      chatter_q <= chatter_d;
    end
  end

  assign clean_out  = clean_q;
  assign change_stb = stb_q;
  assign chatter    = chatter_q;

endmodule

// File: rtl/rpsc_input_debounce.sv
// Per-channel sync/debounce array feeding FF33..FF39_IN, with chatter flags.
// Optional test injection mux on clean_out when RPSC_TEST_INJECT_EN is defined.
module rpsc_input_debounce #(
  parameter int NUM_CH       = rpsc_pkg::RPSC_NUM_FF_CH,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CHATTER_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic              clr_chatter,
`ifdef RPSC_TEST_INJECT_EN
  input  logic              test_en,
  input  logic [NUM_CH-1:0] test_val,
`endif
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] change_stb,
  output logic [NUM_CH-1:0] chatter
);

  logic [NUM_CH-1:0] fsm_clean;
  logic [NUM_CH-1:0] fsm_stb;
  logic [NUM_CH-1:0] fsm_chatter;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rpsc_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CHATTER_MAX  (CHATTER_MAX)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .raw_in      (raw_in[i]),
      .clr_chatter (clr_chatter),
      .clean_out   (fsm_clean[i]),
      .change_stb  (fsm_stb[i]),
      .chatter     (fsm_chatter[i])
    );
  end

  always_comb begin
    clean_out  = fsm_clean;
    change_stb = fsm_stb;
    chatter    = fsm_chatter;
`ifdef RPSC_TEST_INJECT_EN
    // Injection only masks the outputs; the FSMs keep tracking raw_in underneath.
    if (test_en) begin
      clean_out  = test_val;
      change_stb = '0;
      chatter    = '0;
    end
`endif
  end

endmodule

// File: tb/tb_rpsc_input_debounce.sv
// Directed table-driven bench for rpsc_input_debounce (DEBOUNCE_CYC=16, CHATTER_MAX=4);
// injection checks are compiled in when RPSC_TEST_INJECT_EN is defined.
module tb_rpsc_input_debounce;

  typedef struct {
    logic       rst;
    logic [6:0] raw;
    logic       clr;
    int         n;
    logic [6:0] exp_clean;
    logic [6:0] exp_stb;
    logic [6:0] exp_chat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] raw_in;
  logic       clr_chatter;
  logic [6:0] clean_out;
  logic [6:0] change_stb;
  logic [6:0] chatter;
`ifdef RPSC_TEST_INJECT_EN
  logic       test_en;
  logic [6:0] test_val;
`endif

  int         n_vec = 0;
  int         n_bad = 0;
  logic [6:0] stb_acc;
  vec_t       tbl[$];

  always #5 clk = ~clk;

  rpsc_input_debounce #(
    .NUM_CH       (7),
    .DEBOUNCE_CYC (16),
    .CHATTER_MAX  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_in      (raw_in),
    .clr_chatter (clr_chatter),
`ifdef RPSC_TEST_INJECT_EN
    .test_en     (test_en),
    .test_val    (test_val),
`endif
    .clean_out   (clean_out),
    .change_stb  (change_stb),
    .chatter     (chatter)
  );

  // Advance n clocks, returning at a falling edge; ORs every strobe seen on the way.
  task automatic run(input int n);
    stb_acc = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      stb_acc = stb_acc | change_stb;
    end
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [6:0] raw, input logic clr, input int n,
                     input logic [6:0] c, input logic [6:0] s, input logic [6:0] ch);
    vec_t v;
    v.rst = rst; v.raw = raw; v.clr = clr; v.n = n;
    v.exp_clean = c; v.exp_stb = s; v.exp_chat = ch;
    tbl.push_back(v);
  endtask

  initial begin
    // Rising edge on ch0: 18 clocks to clean_out, strobe in exactly the 18th cycle.
    add(0, 7'h01, 0, 17, 7'h00, 7'h00, 7'h00);
    add(0, 7'h01, 0,  1, 7'h01, 7'h01, 7'h00);
    add(0, 7'h01, 0,  1, 7'h01, 7'h00, 7'h00);
    // 15-cycle pulse on ch3 is swallowed (abort 1), then three short pulses bring it to 4.
    add(0, 7'h09, 0, 15, 7'h01, 7'h00, 7'h00);
    add(0, 7'h01, 0, 20, 7'h01, 7'h00, 7'h00);
    add(0, 7'h09, 0,  5, 7'h01, 7'h00, 7'h00);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h00);
    add(0, 7'h09, 0,  5, 7'h01, 7'h00, 7'h00);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h00);
    add(0, 7'h09, 0,  5, 7'h01, 7'h00, 7'h00);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h08);
    // Four 5-cycle pulses on ch6, 10 cycles apart.
    add(0, 7'h41, 0,  5, 7'h01, 7'h00, 7'h08);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h08);
    add(0, 7'h41, 0,  5, 7'h01, 7'h00, 7'h08);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h08);
    add(0, 7'h41, 0,  5, 7'h01, 7'h00, 7'h08);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h08);
    add(0, 7'h41, 0,  5, 7'h01, 7'h00, 7'h08);
    add(0, 7'h01, 0, 10, 7'h01, 7'h00, 7'h48);
    // Clear, then a 5th ch6 abort landing on the same edge as a clear.
    add(0, 7'h01, 1,  1, 7'h01, 7'h00, 7'h00);
    add(0, 7'h41, 0,  5, 7'h01, 7'h00, 7'h00);
    add(0, 7'h01, 0,  2, 7'h01, 7'h00, 7'h00);
    add(0, 7'h01, 1,  1, 7'h01, 7'h00, 7'h40);
    add(0, 7'h01, 0,  5, 7'h01, 7'h00, 7'h40);
    // ch0 falls, then all channels rise together.
    add(0, 7'h00, 0, 17, 7'h01, 7'h00, 7'h40);
    add(0, 7'h00, 0,  1, 7'h00, 7'h01, 7'h40);
    add(0, 7'h7F, 0, 17, 7'h00, 7'h00, 7'h40);
    add(0, 7'h7F, 0,  1, 7'h7F, 7'h7F, 7'h40);
    add(0, 7'h7F, 0,  1, 7'h7F, 7'h00, 7'h40);
    // Falling change pending with cnt=10 is discarded by reset.
    add(0, 7'h00, 0, 12, 7'h7F, 7'h00, 7'h40);
    add(1, 7'h00, 0,  1, 7'h00, 7'h00, 7'h00);
    add(0, 7'h00, 0, 30, 7'h00, 7'h00, 7'h00);

    reset       = 1'b1;
    raw_in      = '0;
    clr_chatter = 1'b0;
`ifdef RPSC_TEST_INJECT_EN
    test_en     = 1'b0;
    test_val    = '0;
`endif
    run(2);
    check("rst_clean", 0, clean_out, 7'h00);
    check("rst_stb",   0, change_stb, 7'h00);
    check("rst_chat",  0, chatter, 7'h00);

    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      run(1);
      check("idle_clean", c, clean_out, 7'h00);
      check("idle_stb",   c, change_stb, 7'h00);
      check("idle_chat",  c, chatter, 7'h00);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      reset       = tbl[i].rst;
      raw_in      = tbl[i].raw;
      clr_chatter = tbl[i].clr;
      run(tbl[i].n);
      check("clean", i, clean_out, tbl[i].exp_clean);
      check("stb",   i, stb_acc,   tbl[i].exp_stb);
      check("chat",  i, chatter,   tbl[i].exp_chat);
    end
    reset       = 1'b0;
    clr_chatter = 1'b0;

`ifdef RPSC_TEST_INJECT_EN
    // Injection overrides immediately; FSMs underneath settle to 7F meanwhile.
    raw_in   = 7'h7F;
    test_val = 7'h55;
    test_en  = 1'b1;
    #1;
    check("inj_clean", 0, clean_out, 7'h55);
    check("inj_stb",   0, change_stb, 7'h00);
    run(20);
    check("inj_hold_clean", 0, clean_out, 7'h55);
    check("inj_hold_stb",   0, stb_acc, 7'h00);
    check("inj_hold_chat",  0, chatter, 7'h00);
    test_en = 1'b0;
    #1;
    check("inj_off_clean", 0, clean_out, 7'h7F);
    check("inj_off_stb",   0, change_stb, 7'h00);
    run(1);
    check("inj_after_clean", 0, clean_out, 7'h7F);
    check("inj_after_stb",   0, stb_acc, 7'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
